// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and pointer-width helper for the opcode fetch front end
package fetch_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int OP_W = 8;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH x 8 in-order byte FIFO with flush, wrap-bit pointers distinguish full from empty
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = ptr_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [OP_W-1:0] din,
  output logic [OP_W-1:0] head,
  output logic [PW-1:0]   count,
  output logic            empty,
  output logic            full
);
  localparam int AW = PW - 1;
  logic [OP_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  assign count = wr - rd;
  assign empty = wr == rd;
  assign full = count == PW'(DEPTH);
  assign head = empty ? '0 : mem[rd[AW-1:0]];
  always_ff @(posedge clk) begin
    wr <= (rst || flush) ? '0 : wr + PW'(push);
    rd <= (rst || flush) ? '0 : rd + PW'(pop);
  end
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/opcode_fetch.sv
// opcode_fetch: opcode prefetch queue with credit-limited fetch, redirect flush/discard; FETCH_STALL_CNT_EN adds stall_cycles
module opcode_fetch
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mc__more,
  output logic [OP_W-1:0]   opcode,
  output logic              mc__stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_gnt,
  input  logic              resp_valid,
  input  logic [OP_W-1:0]   resp_data,
  output logic [ADDR_W-1:0] fetch_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);
  localparam int PW = ptr_w(DEPTH);
  logic [PW-1:0] count, os, dc;
  logic [PW:0] credit;
  logic empty, full, pop, push, issue;
  logic [ADDR_W-1:0] fa, hp;
  assign credit = {1'b0, count} + {1'b0, os};
  assign fetch_req = !rst && credit < (PW+1)'(DEPTH) && os < PW'(MAX_OUT) && !redirect_valid;
  assign issue = fetch_req && fetch_gnt;
  assign pop = !mc__more && !empty && !redirect_valid;
  assign push = resp_valid && dc == '0 && !redirect_valid;
  assign mc__stall = empty;
  assign fetch_addr = fa;
  assign fetch_pc = hp;
  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (resp_data),
    .head  (opcode),
    .count (count),
    .empty (empty),
    .full  (full)
  );
  always_ff @(posedge clk)
    if (rst) begin
      fa <= '0;
      hp <= '0;
      os <= '0;
      dc <= '0;
    end else if (redirect_valid) begin
      fa <= redirect_pc;
      hp <= redirect_pc;
      os <= os - PW'(resp_valid);
      dc <= os - PW'(resp_valid);
    end else begin
      fa <= fa + ADDR_W'(issue);
      hp <= hp + ADDR_W'(pop);
      os <= os + PW'(issue) - PW'(resp_valid);
      dc <= dc - PW'(resp_valid && dc != '0);
    end
`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk)
    stall_cycles <= rst ? '0 : stall_cycles + 32'(!mc__more && empty && stall_cycles != '1);
`endif
  assert property (@(posedge clk) disable iff (rst) !(resp_valid && full && dc == '0));
endmodule

// File: tb/tb_opcode_fetch.sv
// tb_opcode_fetch: table vectors, directed corner sequences and random traffic against a queue-level model
module tb_opcode_fetch;
  localparam int DEPTH = 4;
  localparam int MAX_OUT = 4;
  logic clk = 0, rst = 1, mc__more = 0, redirect_valid = 0, fetch_gnt = 0, resp_valid = 0;
  logic [15:0] redirect_pc = 0;
  logic [7:0] resp_data = 0;
  logic [7:0] opcode;
  logic mc__stall, fetch_req;
  logic [15:0] fetch_addr, fetch_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif
  opcode_fetch #(.DEPTH(DEPTH), .ADDR_W(16), .MAX_OUT(MAX_OUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .mc__more       (mc__more),
    .opcode         (opcode),
    .mc__stall      (mc__stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_req      (fetch_req),
    .fetch_addr     (fetch_addr),
    .fetch_gnt      (fetch_gnt),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .fetch_pc       (fetch_pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic more, gnt, rv;
    logic [7:0] rd;
    logic stall;
    logic [7:0] op;
    logic [15:0] pc;
    logic req;
    logic [15:0] addr;
  } vec_t;
  typedef struct {
    logic [15:0] addr;
    bit stale;
    int rdy;
  } req_t;
  vec_t tbl [6];
  req_t pend [$];
  logic [15:0] exp_q [$];
  logic [15:0] hpc, nfa;
  logic [31:0] sc;
  int cyc, lat_lo, lat_hi, n_iss, checks, errors;
  function automatic logic [7:0] mem(input logic [15:0] a);
    logic [7:0] h;
    h = (a[7:0] * 8'd37) ^ a[15:8] ^ 8'hC3;
    return a == 16'h0 ? 8'h3A : a == 16'h1 ? 8'h5C : h;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic do_reset();
    rst = 1;
    mc__more = 0;
    redirect_valid = 0;
    fetch_gnt = 0;
    resp_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", fetch_req, 0);
    chk("rst_stall", mc__stall, 1);
    chk("rst_opcode", opcode, 0);
    chk("rst_pc", fetch_pc, 0);
    chk("rst_addr", fetch_addr, 0);
    pend.delete();
    exp_q.delete();
    hpc = 0;
    nfa = 0;
    sc = 0;
    cyc = 0;
    rst = 0;
  endtask
  task automatic step(input logic more, input logic redir, input logic [15:0] rpc, input logic gnt);
    logic rv, er;
    logic [7:0] eop;
    mc__more = more;
    redirect_valid = redir;
    redirect_pc = rpc;
    fetch_gnt = gnt;
    rv = pend.size() > 0 && pend[0].rdy <= cyc;
    resp_valid = rv;
    resp_data = rv ? mem(pend[0].addr) : 8'($urandom);
    #1;
    er = (exp_q.size() + pend.size() < DEPTH) && pend.size() < MAX_OUT && !redir;
    eop = exp_q.size() > 0 ? mem(exp_q[0]) : 8'h00;
    chk("stall", mc__stall, exp_q.size() == 0);
    chk("opcode", opcode, eop);
    chk("fetch_pc", fetch_pc, hpc);
    chk("fetch_req", fetch_req, er);
    chk("fetch_addr", fetch_addr, nfa);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, sc);
`endif
    if (fetch_req && gnt) n_iss++;
    if (!more && exp_q.size() == 0 && sc != 32'hFFFF_FFFF) sc++;
    if (redir) begin
      foreach (pend[i]) pend[i].stale = 1;
      exp_q.delete();
      hpc = rpc;
      nfa = rpc;
      if (rv) void'(pend.pop_front());
    end else begin
      if (!more && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        hpc++;
      end
      if (rv) begin
        if (!pend[0].stale) exp_q.push_back(pend[0].addr);
        void'(pend.pop_front());
      end
      if (er && gnt) begin
        pend.push_back('{addr: nfa, stale: 0, rdy: cyc + int'($urandom_range(lat_hi, lat_lo))});
        nfa++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask
  initial begin
    bit seen;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 16'd0, 1'b1, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 16'd0, 1'b1, 16'd1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h3A, 1'b1, 8'h00, 16'd0, 1'b1, 16'd2};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h5C, 1'b0, 8'h3A, 16'd0, 1'b1, 16'd2};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h5C, 16'd1, 1'b1, 16'd2};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 16'd2, 1'b1, 16'd2};
    checks = 0;
    errors = 0;
    lat_lo = 1;
    lat_hi = 1;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      mc__more = tbl[i].more;
      fetch_gnt = tbl[i].gnt;
      resp_valid = tbl[i].rv;
      resp_data = tbl[i].rd;
      redirect_valid = 0;
      #1;
      chk($sformatf("tbl%0d_stall", i), mc__stall, tbl[i].stall);
      chk($sformatf("tbl%0d_opcode", i), opcode, tbl[i].op);
      chk($sformatf("tbl%0d_pc", i), fetch_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_req", i), fetch_req, tbl[i].req);
      chk($sformatf("tbl%0d_addr", i), fetch_addr, tbl[i].addr);
      @(negedge clk);
    end
    do_reset();
    n_iss = 0;
    repeat (12) step(1, 0, 0, 1);
    chk("fill_issues", n_iss, 4);
    chk("fill_req_off", fetch_req, 0);
    chk("fill_not_stalled", mc__stall, 0);
    step(0, 0, 0, 1);
    #1;
    chk("refill_req", fetch_req, 1);
    chk("refill_addr", fetch_addr, 4);
    step(1, 0, 0, 1);
    do_reset();
    lat_lo = 8;
    lat_hi = 8;
    n_iss = 0;
    repeat (3) step(0, 0, 0, 1);
    chk("redir_outstanding", n_iss, 3);
    step(0, 1, 16'h0100, 0);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      #1;
      if (!mc__stall) seen = 1;
      else step(0, 0, 0, 1);
    end
    chk("redir_first_seen", seen, 1);
    chk("redir_first_pc", fetch_pc, 16'h0100);
    chk("redir_first_op", opcode, mem(16'h0100));
    do_reset();
    lat_lo = 2;
    lat_hi = 2;
    repeat (4) step(1, 0, 0, 1);
    step(0, 1, 16'h0200, 1);
    #1;
    chk("same_cyc_stall", mc__stall, 1);
    chk("same_cyc_pc", fetch_pc, 16'h0200);
    chk("same_cyc_op", opcode, 0);
    repeat (12) step(0, 0, 0, 1);
    do_reset();
    repeat (10) step(0, 0, 0, 0);
    #1;
    chk("nognt_req", fetch_req, 1);
    chk("nognt_addr", fetch_addr, 0);
`ifdef FETCH_STALL_CNT_EN
    chk("nognt_stall_cycles", stall_cycles, 10);
`endif
    do_reset();
    lat_lo = 1;
    lat_hi = 1;
    step(0, 1, 16'hFFFE, 1);
    repeat (2) step(0, 0, 0, 1);
    #1;
    chk("wrap_addr", fetch_addr, 16'h0000);
    repeat (6) step(0, 0, 0, 1);
    do_reset();
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 4000; i++) begin
      if (i % 1500 == 1499) do_reset();
      step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 4, 16'($urandom), $urandom_range(0, 99) < 75);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
